// File: rtl/hybrid_controller_llc_pkg.sv
// Shared encodings for the LLC hybrid controller: FSM state codes, sigma command
// encodings (also used by the plant model) and datapath widths.
package hybrid_controller_llc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_POS     = 3'd1,
        ST_DEAD_PN = 3'd2,
        ST_NEG     = 3'd3,
        ST_DEAD_NP = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    localparam logic [1:0] SIGMA_ZERO = 2'b00;
    localparam logic [1:0] SIGMA_POS  = 2'b01;
    localparam logic [1:0] SIGMA_NEG  = 2'b11;

    localparam int S_W   = 34;
    localparam int CNT_W = 16;

    function automatic logic [1:0] sigma_of(state_t st);
        case (st)
            ST_POS:  return SIGMA_POS;
            ST_NEG:  return SIGMA_NEG;
            default: return SIGMA_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/hybrid_controller_llc_switching_surface.sv
// Three-stage switching-surface pipeline: input capture, scaled gain products,
// then surface sum s and the overcurrent flag aligned to the same stage.
module hybrid_controller_llc_switching_surface
    import hybrid_controller_llc_pkg::*;
#(
    parameter int K_V   = 1024,
    parameter int K_I   = 1024,
    parameter int SHIFT = 10,
    parameter int I_MAX = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           vc,
    input  logic [31:0]           is_in,
    output logic signed [S_W-1:0] s,
    output logic                  oc
);

    localparam logic signed [63:0] KV64 = 64'(K_V);
    localparam logic signed [63:0] KI64 = 64'(K_I);

    logic signed [31:0]    vc_q, vc_d, is_q, is_d, is2_q, is2_d;
    logic signed [63:0]    prod_v, prod_i;
    logic signed [S_W-1:0] pv_q, pv_d, pi_q, pi_d, s_q, s_d;
    logic [32:0]           is_mag;
    logic                  oc_q, oc_d;

    always_comb begin
        vc_d   = vc;
        is_d   = is_in;
        prod_v = 64'(vc_q) * KV64;
        prod_i = 64'(is_q) * KI64;
        pv_d   = S_W'(prod_v >>> SHIFT);
        pi_d   = S_W'(prod_i >>> SHIFT);
        // iS rides alongside the products so oc lands in the same stage as s
        is2_d  = is_q;
        s_d    = pv_q + pi_q;
        is_mag = is2_q[31] ? (33'd0 - 33'(is2_q)) : 33'(is2_q);
        oc_d   = is_mag > 33'(I_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vc_q  <= '0;
            is_q  <= '0;
            pv_q  <= '0;
            pi_q  <= '0;
            is2_q <= '0;
            s_q   <= '0;
            oc_q  <= 1'b0;
        end else begin
            vc_q  <= vc_d;
            is_q  <= is_d;
            pv_q  <= pv_d;
            pi_q  <= pi_d;
            is2_q <= is2_d;
            s_q   <= s_d;
            oc_q  <= oc_d;
        end
    end

    assign s  = s_q;
    assign oc = oc_q;

endmodule

// File: rtl/hybrid_controller_llc.sv
// LLC hybrid switching controller: surface pipeline feeding a POS/DEAD/NEG FSM with
// hysteresis, minimum on-time, dead time and a latched overcurrent trip.
module hybrid_controller_llc
    import hybrid_controller_llc_pkg::*;
#(
    parameter int K_V      = 1024,
    parameter int K_I      = 1024,
    parameter int SHIFT    = 10,
    parameter int H        = 1000,
    parameter int DEAD_CYC = 5,
    parameter int MIN_ON   = 20,
    parameter int I_MAX    = 50_000_000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic        FAULT_CLR,
    input  logic [31:0] vC,
    input  logic [31:0] iS,
    output logic [1:0]  sigma,
    output logic        switch_pulse,
    output logic        fault,
    output logic [2:0]  state
);

    localparam logic signed [S_W-1:0] H_POS     = S_W'(H);
    localparam logic signed [S_W-1:0] H_NEG     = -H_POS;
    localparam logic [CNT_W-1:0]      ON_LAST   = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0]      DEAD_LAST = CNT_W'(DEAD_CYC > 0 ? DEAD_CYC - 1 : 0);

    logic signed [S_W-1:0] s_q;
    logic                  oc_q;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  on_cnt_q, on_cnt_d, dead_cnt_q, dead_cnt_d;
    logic [1:0]        sigma_q, sigma_d;
    logic              pulse_q, pulse_d, fault_q, fault_d;
    logic              on_done;

    hybrid_controller_llc_switching_surface #(
        .K_V(K_V), .K_I(K_I), .SHIFT(SHIFT), .I_MAX(I_MAX)
    ) u_surface (
        .clk(CLK), .rst_n(RESET), .vc(vC), .is_in(iS), .s(s_q), .oc(oc_q)
    );

    always_comb begin
        state_d    = state_q;
        on_cnt_d   = on_cnt_q;
        dead_cnt_d = dead_cnt_q;
        pulse_d    = 1'b0;
        fault_d    = fault_q;
        on_done    = on_cnt_q >= ON_LAST;

        if (state_q == ST_FAULT) begin
            // a clear request coinciding with a live overcurrent keeps the trip latched
            if (FAULT_CLR && !ENABLE && !oc_q) begin
                state_d = ST_IDLE;
                fault_d = 1'b0;
            end
        end else if (oc_q) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
        end else if (!ENABLE) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fault_q) begin
                        state_d  = ST_POS;
                        on_cnt_d = '0;
                        pulse_d  = 1'b1;
                    end
                end
                ST_POS: begin
                    if (on_done && s_q >= H_POS) begin
                        if (DEAD_CYC == 0) begin
                            state_d  = ST_NEG;
                            on_cnt_d = '0;
                            pulse_d  = 1'b1;
                        end else begin
                            state_d    = ST_DEAD_PN;
                            dead_cnt_d = '0;
                        end
                    end else if (on_cnt_q != '1) begin
                        on_cnt_d = on_cnt_q + 1'b1;
                    end
                end
                ST_NEG: begin
                    if (on_done && s_q <= H_NEG) begin
                        if (DEAD_CYC == 0) begin
                            state_d  = ST_POS;
                            on_cnt_d = '0;
                            pulse_d  = 1'b1;
                        end else begin
                            state_d    = ST_DEAD_NP;
                            dead_cnt_d = '0;
                        end
                    end else if (on_cnt_q != '1) begin
                        on_cnt_d = on_cnt_q + 1'b1;
                    end
                end
                ST_DEAD_PN, ST_DEAD_NP: begin
                    if (dead_cnt_q >= DEAD_LAST) begin
                        state_d  = (state_q == ST_DEAD_PN) ? ST_NEG : ST_POS;
                        on_cnt_d = '0;
                        pulse_d  = 1'b1;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        sigma_d = sigma_of(state_d);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            on_cnt_q   <= '0;
            dead_cnt_q <= '0;
            sigma_q    <= SIGMA_ZERO;
            pulse_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            on_cnt_q   <= on_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            sigma_q    <= sigma_d;
            pulse_q    <= pulse_d;
            fault_q    <= fault_d;
        end
    end

    assign sigma        = sigma_q;
    assign switch_pulse = pulse_q;
    assign fault        = fault_q;
    assign state        = state_q;

endmodule

// File: tb/tb_hybrid_controller_llc.sv
// Randomized bench for two controller configurations (with and without dead time)
// against a cycle-level behavioural model of the switching rules.
module tb_hybrid_controller_llc;

    localparam int KV = 1024, KI = 1024, SH = 10, HB = 1000, IMAX = 50_000_000;
    localparam int DEAD_A = 5, MIN_A = 20, DEAD_B = 0, MIN_B = 3;

    logic        CLK = 1'b0, RESET = 1'b0, ENABLE = 1'b1, FAULT_CLR = 1'b0;
    logic [31:0] vC = '0, iS = '0;
    logic [1:0]  sigma_a, sigma_b;
    logic        pulse_a, pulse_b, fault_a, fault_b;
    logic [2:0]  state_a, state_b;

    int n_chk = 0, n_err = 0;

    hybrid_controller_llc #(.K_V(KV), .K_I(KI), .SHIFT(SH), .H(HB), .DEAD_CYC(DEAD_A),
                            .MIN_ON(MIN_A), .I_MAX(IMAX)) u_dut_a (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .FAULT_CLR(FAULT_CLR), .vC(vC), .iS(iS),
        .sigma(sigma_a), .switch_pulse(pulse_a), .fault(fault_a), .state(state_a));

    hybrid_controller_llc #(.K_V(KV), .K_I(KI), .SHIFT(SH), .H(HB), .DEAD_CYC(DEAD_B),
                            .MIN_ON(MIN_B), .I_MAX(IMAX)) u_dut_b (
        .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .FAULT_CLR(FAULT_CLR), .vC(vC), .iS(iS),
        .sigma(sigma_b), .switch_pulse(pulse_b), .fault(fault_b), .state(state_b));

    always #5 CLK = ~CLK;

    // reference model: surface values in flight, plus per-config switching status
    longint pipe_s[$];
    bit     pipe_oc[$];
    int     m_pol[2], m_on[2], m_dead[2];
    bit     m_act[2], m_indead[2], m_flt[2], m_pulse[2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d want %0d", tag, $time, obs, exp);
        end
    endtask

    function automatic longint surf(logic [31:0] v, logic [31:0] i);
        longint vl = longint'($signed(v));
        longint il = longint'($signed(i));
        return ((vl * KV) >>> SH) + ((il * KI) >>> SH);
    endfunction

    function automatic bit over(logic [31:0] i);
        longint il = longint'($signed(i));
        if (il < 0) il = -il;
        return il > IMAX;
    endfunction

    task automatic model_reset();
        pipe_s.delete();
        pipe_oc.delete();
        repeat (3) begin
            pipe_s.push_back(0);
            pipe_oc.push_back(1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            m_pol[k] = 1; m_on[k] = 0; m_dead[k] = 0;
            m_act[k] = 0; m_indead[k] = 0; m_flt[k] = 0; m_pulse[k] = 0;
        end
    endtask

    task automatic model_edge();
        longint s = pipe_s.pop_front();
        bit     oc = pipe_oc.pop_front();
        pipe_s.push_back(surf(vC, iS));
        pipe_oc.push_back(over(iS));
        for (int k = 0; k < 2; k++) begin
            int  dc = (k == 0) ? DEAD_A : DEAD_B;
            int  mo = (k == 0) ? MIN_A : MIN_B;
            bit  want;
            m_pulse[k] = 0;
            if (m_flt[k]) begin
                if (FAULT_CLR && !ENABLE && !oc) m_flt[k] = 0;
            end else if (oc) begin
                m_flt[k] = 1; m_act[k] = 0; m_indead[k] = 0;
            end else if (!ENABLE) begin
                m_act[k] = 0; m_indead[k] = 0;
            end else if (!m_act[k]) begin
                m_act[k] = 1; m_pol[k] = 1; m_on[k] = 0; m_pulse[k] = 1;
            end else if (m_indead[k]) begin
                m_dead[k]++;
                if (m_dead[k] >= dc) begin
                    m_indead[k] = 0; m_on[k] = 0; m_pulse[k] = 1;
                end
            end else begin
                want = (m_pol[k] > 0) ? (s >= HB) : (s <= -HB);
                if (m_on[k] >= mo - 1 && want) begin
                    m_pol[k] = -m_pol[k];
                    if (dc == 0) begin
                        m_on[k] = 0; m_pulse[k] = 1;
                    end else begin
                        m_indead[k] = 1; m_dead[k] = 0;
                    end
                end else begin
                    m_on[k]++;
                end
            end
        end
    endtask

    function automatic int exp_sigma(int k);
        if (m_flt[k] || !m_act[k] || m_indead[k]) return 0;
        return (m_pol[k] > 0) ? 1 : 3;
    endfunction

    function automatic int exp_state(int k);
        if (m_flt[k]) return 5;
        if (!m_act[k]) return 0;
        if (m_indead[k]) return (m_pol[k] < 0) ? 2 : 4;
        return (m_pol[k] > 0) ? 1 : 3;
    endfunction

    task automatic compare_all();
        chk("a_sigma", 64'(sigma_a), 64'(exp_sigma(0)));
        chk("a_pulse", 64'(pulse_a), 64'(m_pulse[0]));
        chk("a_fault", 64'(fault_a), 64'(m_flt[0]));
        chk("a_state", 64'(state_a), 64'(exp_state(0)));
        chk("b_sigma", 64'(sigma_b), 64'(exp_sigma(1)));
        chk("b_pulse", 64'(pulse_b), 64'(m_pulse[1]));
        chk("b_fault", 64'(fault_b), 64'(m_flt[1]));
        chk("b_state", 64'(state_b), 64'(exp_state(1)));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sigma_a"}, 64'(sigma_a), 64'd0);
        chk({tag, "_sigma_b"}, 64'(sigma_b), 64'd0);
        chk({tag, "_flags"}, 64'({pulse_a, fault_a, pulse_b, fault_b}), 64'd0);
        chk({tag, "_state"}, 64'({state_a, state_b}), 64'd0);
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    // asynchronous reset dropped mid-cycle while the loop is running
    task automatic do_reset();
        #2 RESET = 1'b0;
        #1 check_zero("async_rst");
        model_reset();
        repeat (2) begin
            @(posedge CLK);
            #1 check_zero("held_rst");
        end
        @(negedge CLK) RESET = 1'b1;
    endtask

    initial begin
        int vt[9] = '{0, 999, 1000, -999, -1000, 1500, -1500, 2000, -2000};
        int ot[5] = '{50_000_001, 50_000_000, -50_000_001, -50_000_000, 32'h8000_0000};
        int len;

        model_reset();
        #12 check_zero("rst_hold_en");
        @(negedge CLK) RESET = 1'b1;
        step();
        chk("first_sigma", 64'(sigma_a), 64'd1);
        chk("first_pulse", 64'(pulse_a), 64'd1);

        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 4) == 0) vC = 32'($urandom_range(0, 6000)) - 32'd3000;
            else vC = vt[$urandom_range(0, 8)];
            iS  = '0;
            len = $urandom_range(1, 40);
            if ($urandom_range(0, 99) < 4) begin
                iS  = ot[$urandom_range(0, 4)];
                len = $urandom_range(1, 3);
            end
            if (m_flt[0] || m_flt[1]) ENABLE = ($urandom_range(0, 2) != 0);
            else ENABLE = ($urandom_range(0, 9) != 0);
            FAULT_CLR = ($urandom_range(0, 3) == 0);
            repeat (len) step();
            if (seg == 70 || seg == 140) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
